// File: rtl/axi_read_arbiter_pkg.sv
// Shared types and constants for the N-way AXI4 read arbiter.
// Imported by the arbiter top and its testbench.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ADDR,
    ARB_DATA
  } arb_state_t;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [2:0] SIZE_WORD   = 3'b010;
  localparam logic [7:0] LEN_LINE    = 8'd15;

  function automatic logic [7:0] sat_inc(
    input logic [7:0] v
  );
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/axi_read_arbiter_if.sv
// Upstream per-master request/response bundle plus the AXI AR/R port.
// master = arbiter side, slave = environment side.
interface axi_read_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int ID_W        = 4
);
  logic [NUM_MASTERS-1:0]        m_arvalid;
  logic [NUM_MASTERS*ADDR_W-1:0] m_araddr;
  logic [NUM_MASTERS*8-1:0]      m_arlen;
  logic [NUM_MASTERS*3-1:0]      m_arsize;
  logic [NUM_MASTERS*2-1:0]      m_arburst;
  logic [NUM_MASTERS-1:0]        m_arready;
  logic [NUM_MASTERS-1:0]        m_rvalid;
  logic [DATA_W-1:0]             m_rdata;
  logic [1:0]                    m_rresp;
  logic                          m_rlast;

  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;
  logic              busy;
  logic              err;

  modport master (
    input  m_arvalid, m_araddr, m_arlen,
    input  m_arsize, m_arburst,
    output m_arready, m_rvalid, m_rdata,
    output m_rresp, m_rlast,
    output arid, araddr, arlen, arsize,
    output arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready, busy, err
  );

  modport slave (
    output m_arvalid, m_araddr, m_arlen,
    output m_arsize, m_arburst,
    input  m_arready, m_rvalid, m_rdata,
    input  m_rresp, m_rlast,
    input  arid, araddr, arlen, arsize,
    input  arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready, busy, err
  );

endinterface

// File: rtl/axi_read_arbiter_rr_arbiter.sv
// Combinational request picker: round-robin from rr_ptr,
// or fixed priority with the highest index winning.
module rr_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int FIXED_PRIO  = 0,
  localparam int IDX_W = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       rr_ptr,
  output logic [NUM_MASTERS-1:0] gnt,
  output logic [IDX_W-1:0]       gnt_idx,
  output logic                   any_req
);

  localparam logic [IDX_W:0] NM =
    (IDX_W+1)'(NUM_MASTERS);

  logic [IDX_W:0] pos;
  logic           found;

  assign any_req = |req;

  always_comb begin
    gnt_idx = '0;
    found   = 1'b0;
    pos     = '0;
    if (FIXED_PRIO != 0) begin
      for (int i = 0; i < NUM_MASTERS; i++)
        if (req[i]) gnt_idx = IDX_W'(i);
    end else begin
      for (int k = 0; k < NUM_MASTERS; k++) begin
        pos = {1'b0, rr_ptr} + (IDX_W+1)'(k);
        if (pos >= NM) pos = pos - NM;
        if (!found && req[pos[IDX_W-1:0]]) begin
          found   = 1'b1;
          gnt_idx = pos[IDX_W-1:0];
        end
      end
    end
  end

  assign gnt = any_req ?
    (NUM_MASTERS'(1) << gnt_idx) : '0;

endmodule

// File: rtl/axi_read_arbiter.sv
// N-master AXI4 read arbiter: one outstanding burst, AR registered,
// R beats steered to the owner, burst length and ID checked.
module axi_read_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int ID_W        = 4,
  parameter int FIXED_PRIO  = 0
) (
  input logic clk,
  input logic rst,
  axi_read_arbiter_if.master bus
);

  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(NUM_MASTERS-1);

  arb_state_t             state;
  logic [IDX_W-1:0]       rr_ptr;
  logic [IDX_W-1:0]       gnt_idx;
  logic [NUM_MASTERS-1:0] gnt;
  logic [NUM_MASTERS-1:0] owner;
  logic                   any_req;
  logic [7:0]             beat_cnt;

  logic [ID_W-1:0]   arid_q;
  logic [ADDR_W-1:0] araddr_q;
  logic [7:0]        arlen_q;
  logic [2:0]        arsize_q;
  logic [1:0]        arburst_q;

  logic [ADDR_W-1:0] sel_addr;
  logic [7:0]        sel_len;
  logic [2:0]        sel_size;
  logic [1:0]        sel_burst;
  logic              in_data;

  rr_arbiter #(
    .NUM_MASTERS (NUM_MASTERS),
    .FIXED_PRIO  (FIXED_PRIO)
  ) u_arb (
    .req     (bus.m_arvalid),
    .rr_ptr  (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any_req (any_req)
  );

  always_comb begin
    sel_addr  = '0;
    sel_len   = '0;
    sel_size  = '0;
    sel_burst = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (gnt[i]) begin
        sel_addr  = bus.m_araddr[i*ADDR_W +: ADDR_W];
        sel_len   = bus.m_arlen[i*8 +: 8];
        sel_size  = bus.m_arsize[i*3 +: 3];
        sel_burst = bus.m_arburst[i*2 +: 2];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ARB_IDLE;
      rr_ptr    <= '0;
      beat_cnt  <= '0;
      owner     <= '0;
      arid_q    <= '0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
      arburst_q <= '0;
    end else begin
      unique case (state)
        ARB_IDLE: begin
          if (any_req) begin
            state     <= ARB_ADDR;
            owner     <= gnt;
            arid_q    <= ID_W'(gnt_idx);
            araddr_q  <= sel_addr;
            arlen_q   <= sel_len;
            arsize_q  <= sel_size;
            arburst_q <= sel_burst;
            if (FIXED_PRIO == 0)
              rr_ptr <= (gnt_idx == LAST) ?
                '0 : gnt_idx + IDX_W'(1);
          end
        end
        ARB_ADDR: begin
          if (bus.arready) begin
            state    <= ARB_DATA;
            beat_cnt <= '0;
          end
        end
        ARB_DATA: begin
          if (bus.rvalid) begin
            beat_cnt <= sat_inc(beat_cnt);
            if (bus.rlast) state <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign in_data = (state == ARB_DATA);

  // Grant is masked while reset is held so no master sees a handshake.
  assign bus.m_arready =
    (rst && state == ARB_IDLE) ? gnt : '0;
  assign bus.m_rvalid =
    (in_data && bus.rvalid) ? owner : '0;
  assign bus.m_rdata = bus.rdata;
  assign bus.m_rresp = bus.rresp;
  assign bus.m_rlast = bus.rlast;

  assign bus.arid    = arid_q;
  assign bus.araddr  = araddr_q;
  assign bus.arlen   = arlen_q;
  assign bus.arsize  = arsize_q;
  assign bus.arburst = arburst_q;
  assign bus.arvalid = (state == ARB_ADDR);
  assign bus.rready  = in_data;
  assign bus.busy    = (state != ARB_IDLE);

  assign bus.err = in_data && bus.rvalid && (
    (bus.rlast && beat_cnt != arlen_q) ||
    (!bus.rlast && beat_cnt == arlen_q) ||
    (bus.rid != arid_q));

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Randomized bench: round-robin and fixed-priority arbiters checked
// every cycle against a transaction-level reference model.
module tb_axi_read_arbiter;
  import axi_arb_pkg::*;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int req_pct  = 30;
  bit bad_en   = 1'b0;
  bit stray_en = 1'b1;
  bit line_en  = 1'b0;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s got=%0h exp=%0h t=%0t",
                 tag, got, exp, $time);
    end
  endtask

  for (genvar d = 0; d < 2; d++) begin : g_dut
    axi_read_arbiter_if #(
      .NUM_MASTERS (N),
      .ADDR_W      (AW),
      .DATA_W      (DW),
      .ID_W        (IW)
    ) bus ();

    axi_read_arbiter #(
      .NUM_MASTERS (N),
      .ADDR_W      (AW),
      .DATA_W      (DW),
      .ID_W        (IW),
      .FIXED_PRIO  (d)
    ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    // pending master requests
    logic [N-1:0]  pv;
    logic [AW-1:0] pa [N];
    logic [7:0]    pl [N];
    logic [2:0]    ps [N];
    logic [1:0]    pb [N];

    // open transaction
    bit            open;
    bit            ar_ok;
    bit            bad_id;
    int            cur;
    int            nxt;
    int            beats;
    int            ar_wait;
    int            last_at;
    logic [AW-1:0] caddr;
    logic [7:0]    clen;
    logic [2:0]    csize;
    logic [1:0]    cburst;
    string         pfx;

    function automatic int pick();
      int g;
      g = -1;
      if (d == 1) begin
        for (int i = 0; i < N; i++)
          if (pv[i]) g = i;
      end else begin
        for (int k = 0; k < N; k++) begin
          int j;
          j = (nxt + k) % N;
          if (g < 0 && pv[j]) g = j;
        end
      end
      return g;
    endfunction

    initial begin
      int            g;
      logic [N-1:0]  eg;
      logic [N-1:0]  erv;
      bit            e;
      pfx = (d == 0) ? "rr_" : "fp_";
      pv = '0;
      open = 1'b0;
      ar_ok = 1'b0;
      bad_id = 1'b0;
      cur = 0; nxt = 0; beats = 0;
      ar_wait = 0; last_at = 0;
      caddr = '0; clen = '0;
      csize = '0; cburst = '0;
      for (int i = 0; i < N; i++) begin
        pa[i] = '0; pl[i] = '0;
        ps[i] = '0; pb[i] = '0;
      end
      bus.m_arvalid = '0;
      bus.m_araddr  = '0;
      bus.m_arlen   = '0;
      bus.m_arsize  = '0;
      bus.m_arburst = '0;
      bus.arready   = 1'b0;
      bus.rvalid    = 1'b0;
      bus.rlast     = 1'b0;
      bus.rid       = '0;
      bus.rdata     = '0;
      bus.rresp     = '0;
      forever begin
        @(negedge clk);
        if (!rst) begin
          chk({pfx, "rst_busy"}, 64'(bus.busy), 64'(0));
          chk({pfx, "rst_arvalid"},
              64'(bus.arvalid), 64'(0));
          chk({pfx, "rst_rready"},
              64'(bus.rready), 64'(0));
          chk({pfx, "rst_m_arready"},
              64'(bus.m_arready), 64'(0));
          chk({pfx, "rst_m_rvalid"},
              64'(bus.m_rvalid), 64'(0));
          chk({pfx, "rst_err"}, 64'(bus.err), 64'(0));
          chk({pfx, "rst_araddr"},
              64'(bus.araddr), 64'(0));
          chk({pfx, "rst_arid"}, 64'(bus.arid), 64'(0));
          chk({pfx, "rst_arlen"},
              64'(bus.arlen), 64'(0));
          open = 1'b0;
          ar_ok = 1'b0;
          pv = '0;
          nxt = 0;
          beats = 0;
        end else begin
          g = open ? -1 : pick();
          eg = '0;
          if (g >= 0) eg[g] = 1'b1;
          chk({pfx, "m_arready"},
              64'(bus.m_arready), 64'(eg));
          chk({pfx, "busy"}, 64'(bus.busy), 64'(open));
          chk({pfx, "arvalid"}, 64'(bus.arvalid),
              64'(open && !ar_ok));
          chk({pfx, "rready"}, 64'(bus.rready),
              64'(open && ar_ok));
          if (open) begin
            chk({pfx, "arid"}, 64'(bus.arid), 64'(cur));
            chk({pfx, "araddr"},
                64'(bus.araddr), 64'(caddr));
            chk({pfx, "arlen"}, 64'(bus.arlen), 64'(clen));
            chk({pfx, "arsize"},
                64'(bus.arsize), 64'(csize));
            chk({pfx, "arburst"},
                64'(bus.arburst), 64'(cburst));
          end
          erv = '0;
          if (open && ar_ok && bus.rvalid) erv[cur] = 1'b1;
          chk({pfx, "m_rvalid"},
              64'(bus.m_rvalid), 64'(erv));
          chk({pfx, "m_rdata"},
              64'(bus.m_rdata), 64'(bus.rdata));
          chk({pfx, "m_rresp"},
              64'(bus.m_rresp), 64'(bus.rresp));
          chk({pfx, "m_rlast"},
              64'(bus.m_rlast), 64'(bus.rlast));
          e = open && ar_ok && bus.rvalid && (
            (bus.rlast && beats != int'(clen)) ||
            (!bus.rlast && beats == int'(clen)) ||
            (int'(bus.rid) != cur));
          chk({pfx, "err"}, 64'(bus.err), 64'(e));

          if (!open) begin
            if (g >= 0) begin
              open = 1'b1;
              ar_ok = 1'b0;
              cur = g;
              caddr = pa[g];
              clen = pl[g];
              csize = ps[g];
              cburst = pb[g];
              pv[g] = 1'b0;
              nxt = (g + 1) % N;
              ar_wait = $urandom_range(5);
              bad_id = bad_en && ($urandom_range(5) == 0);
              last_at = int'(clen);
              if (bad_en) begin
                case ($urandom_range(4))
                  0: if (clen > 0) last_at = int'(clen) - 1;
                  1: last_at = int'(clen) + 1;
                  default: ;
                endcase
              end
            end
          end else if (!ar_ok) begin
            if (bus.arready) begin
              ar_ok = 1'b1;
              beats = 0;
            end
          end else if (bus.rvalid) begin
            beats++;
            if (bus.rlast) open = 1'b0;
          end
        end

        @(posedge clk);
        #1;
        if (!rst) begin
          bus.m_arvalid = '0;
          bus.arready   = 1'b0;
          bus.rvalid    = 1'b0;
          bus.rlast     = 1'b0;
        end else begin
          for (int i = 0; i < N; i++) begin
            if (!pv[i] && $urandom_range(99) < req_pct) begin
              pv[i] = 1'b1;
              pa[i] = $urandom;
              if (line_en) begin
                pl[i] = LEN_LINE;
                ps[i] = SIZE_WORD;
                pb[i] = BURST_INCR;
              end else begin
                pl[i] = 8'($urandom_range(15));
                ps[i] = 3'($urandom_range(7));
                pb[i] = ($urandom_range(1) != 0) ?
                  BURST_INCR : BURST_FIXED;
              end
            end
          end
          bus.m_arvalid = pv;
          for (int i = 0; i < N; i++) begin
            bus.m_araddr[i*AW +: AW] = pa[i];
            bus.m_arlen[i*8 +: 8]    = pl[i];
            bus.m_arsize[i*3 +: 3]   = ps[i];
            bus.m_arburst[i*2 +: 2]  = pb[i];
          end
          if (open && !ar_ok) begin
            bus.arready = (ar_wait == 0);
            if (ar_wait > 0) ar_wait--;
          end else begin
            bus.arready = ($urandom_range(1) != 0);
          end
          if (open && ar_ok) begin
            bus.rvalid = ($urandom_range(3) != 0);
            bus.rlast  = bus.rvalid && (beats == last_at);
            bus.rid    = bad_id ? IW'(cur ^ 1) : IW'(cur);
          end else begin
            bus.rvalid = stray_en &&
              ($urandom_range(5) == 0);
            bus.rlast  = ($urandom_range(1) != 0);
            bus.rid    = IW'($urandom_range(N-1));
          end
          bus.rdata = $urandom;
          bus.rresp = 2'($urandom_range(3));
        end
      end
    end
  end

  initial begin
    int found;
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;

    req_pct = 30;
    repeat (600) @(posedge clk);

    req_pct = 100;
    repeat (400) @(posedge clk);

    bad_en = 1'b1;
    req_pct = 50;
    repeat (400) @(posedge clk);

    bad_en = 1'b0;
    line_en = 1'b1;
    req_pct = 100;
    found = 0;
    for (int c = 0; c < 3000 && found == 0; c++) begin
      @(posedge clk);
      if (g_dut[0].open && g_dut[0].ar_ok &&
          g_dut[0].beats == 7)
        found = 1;
    end
    chk("mid_burst_reached", 64'(found), 64'(1));
    #3 rst = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;

    line_en = 1'b0;
    req_pct = 40;
    repeat (500) @(posedge clk);

    #1;
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_read_arbiter.md
Name: axi_read_arbiter

Overview:
- Parametrised N-master AXI4 read-channel arbiter; successor to the fixed two-way inst/data read mux in the MMU top level.
- Grants one master at a time, using round-robin or fixed priority.
- Registers the AR request and routes R beats to the granted master until rlast.
- Checks burst length and ID, and flags protocol errors.
- Sits between the inst/data/uncached MMU channels and the single AXI master port.

Parameters:
- NUM_MASTERS, 2, number of requesting channels (2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, R data width.
- ID_W, 4, AXI ID width; must satisfy 2^ID_W >= NUM_MASTERS.
- FIXED_PRIO, 0, 0 = round-robin; 1 = fixed priority, highest index wins.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst  in  1  asynchronous active-low reset (asserted when 0).
- m_arvalid  in  NUM_MASTERS  per-master read request.
- m_araddr  in  NUM_MASTERS*ADDR_W  per-master address, packed, master i at [i*ADDR_W +: ADDR_W].
- m_arlen  in  NUM_MASTERS*8  per-master burst length-1.
- m_arsize  in  NUM_MASTERS*3  per-master beat size.
- m_arburst  in  NUM_MASTERS*2  per-master burst type.
- m_arready  out  NUM_MASTERS  request accepted (one-hot pulse).
- m_rvalid  out  NUM_MASTERS  beat valid to the granted master only.
- m_rdata  out  DATA_W  broadcast read data.
- m_rresp  out  2  broadcast response.
- m_rlast  out  1  broadcast last.
- arid  out  ID_W  granted master index.
- araddr  out  ADDR_W  registered address.
- arlen  out  8  registered length.
- arsize  out  3  registered size.
- arburst  out  2  registered burst type.
- arvalid  out  1  AXI AR valid.
- arready  in  1  AXI AR ready.
- rid  in  ID_W  AXI R id.
- rdata  in  DATA_W  AXI R data.
- rresp  in  2  AXI R response.
- rlast  in  1  AXI R last.
- rvalid  in  1  AXI R valid.
- rready  out  1  AXI R ready.
- busy  out  1  state != IDLE.
- err  out  1  one-cycle pulse on protocol error.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; rr_ptr=0; beat_cnt=0.
  - All AR registers 0.
  - arvalid, rready, m_arready, m_rvalid, err and busy all 0.
- IDLE:
  - If any m_arvalid: the arbiter picks grant g and m_arready[g]=1 combinationally in the same cycle.
  - Latch araddr/arlen/arsize/arburst from master g; arid=g; expected length exp_len=arlen.
  - Next state ADDR. Non-granted masters see no m_arready.
  - Masters hold payload stable while m_arvalid=1 and m_arready=0.
- ADDR:
  - arvalid=1, payload constant. On arready=1, go to DATA and clear beat_cnt.
  - No timeout; arvalid is held indefinitely.
- DATA:
  - rready=1; m_rvalid[g]=rvalid; other m_rvalid bits are 0.
  - m_rdata, m_rresp and m_rlast are driven combinationally from rdata, rresp and rlast (zero added latency).
  - Each rvalid beat increments beat_cnt (8-bit, saturating at 255).
  - On rvalid&rlast, go to IDLE. The next grant can occur in the following IDLE cycle, so there is one bubble between transactions.
- Minimum latency: m_arvalid at cycle t gives arvalid at t+1. A single-beat read with arready and rvalid each asserted after one cycle takes 3 cycles round trip.
- Arbitration:
  - Round-robin: search starts at rr_ptr. After each grant, rr_ptr=(g+1) mod NUM_MASTERS, with wrap-around at NUM_MASTERS-1 back to 0. No master waits more than NUM_MASTERS-1 transactions.
  - Fixed: highest asserted index wins; rr_ptr is unused.
- Exactly one transaction is outstanding at any time; requests arriving while busy wait.
- Error checks (err pulses for 1 cycle; the beat is still forwarded):
  - rlast while beat_cnt != exp_len.
  - rvalid without rlast while beat_cnt == exp_len.
  - rid != arid on any beat.
  - rvalid in IDLE or ADDR: the beat is dropped (rready=0 there) and err is not raised.
- Simultaneous rlast and new m_arvalid in the same cycle: the new request is not granted until the next cycle.
- Reset mid-burst: everything returns to IDLE immediately. Remaining R beats arrive with rready=0 after reset releases, so they are not consumed. Downstream must also be reset.

Decomposition:
- Package axi_arb_pkg:
  - typedef enum logic[1:0] {ARB_IDLE, ARB_ADDR, ARB_DATA} arb_state_t;
  - constants BURST_FIXED=2'd0, BURST_INCR=2'd1, SIZE_WORD=3'b010, LEN_LINE=8'd15.
- One sub-module, rr_arbiter:
  - Parameters NUM_MASTERS, FIXED_PRIO.
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot grant, grant index, any_req.
  - Purely combinational.
- rr_ptr register and FSM live in the top module.

Test Plan:
- Single master 0, arlen=15, INCR -> arvalid at t+1, arid=0, 16 beats routed to m_rvalid[0] only, err=0, IDLE after rlast.
- Round-robin, masters 0 and 1 requesting continuously -> grants alternate 0,1,0,1 with one idle cycle between transactions; arid matches each grant.
- FIXED_PRIO=1, NUM_MASTERS=3, all requesting -> master 2 granted repeatedly; master 0 granted only after 2 and 1 drop.
- arready held low for 5 cycles -> arvalid=1 and payload constant for all 5; DATA entered on the cycle after arready.
- arlen=3 with rlast on beat 2 -> err pulses on that beat, FSM returns to IDLE; separately rid=1 with arid=0 -> err on each beat.
- rst low during beat 7 of 16 -> immediately IDLE, all outputs 0, rr_ptr=0; a new request after release is granted normally.
